// File: rtl/mac_tx_pkg.sv
// Shared constants for the MAC transmit FIFO and its CRC-32 (FCS) engine.
package mac_tx_pkg;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
   localparam int          FIFO_DEPTH      = 2048;

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational reflected CRC-32 update: folds one byte into the CRC, LSB first.
module crc32_byte_step
   import mac_tx_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   logic [31:0] c;

   always_comb begin
      c = crc_i;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data_i[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
         else                  c = c >> 1;
      end
      crc_o = c;
   end

endmodule

// File: rtl/mac_tx_fifo_crc.sv
// Byte-wide TX FIFO plus an independent CRC-32 (FCS) accumulator for the MAC.
// Define MAC_TX_FIFO_ERR_EN to add sticky tx_fifo_overflow / tx_fifo_underflow outputs.
module mac_tx_fifo_crc
   import mac_tx_pkg::*;
#(
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        tx_fifo_wr_data,
   input  logic              tx_fifo_wr_en,
   input  logic              tx_fifo_rd_en,
   output logic [7:0]        tx_fifo_rd_data,
   output logic              tx_fifo_full,
   output logic              tx_fifo_empty,
   output logic [ADDR_W:0]   tx_fifo_level,
   input  logic [7:0]        data_in,
   input  logic              crc_init,
   input  logic              crc_en,
   output logic [31:0]       crc_out
`ifdef MAC_TX_FIFO_ERR_EN
   ,
   output logic              tx_fifo_overflow,
   output logic              tx_fifo_underflow
`endif
);

   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   LVL_DEPTH = (ADDR_W+1)'(DEPTH);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic [7:0]        rd_data_q;
   logic [31:0]       crc_q, crc_d, crc_next;
   logic              full, empty, rd_acc, wr_acc;

   // Handshake: a read is accepted when rd_en && !empty (data appears next cycle);
   // a write is accepted when wr_en && (!full || read accepted this edge).
   assign full   = (level_q == LVL_DEPTH);
   assign empty  = (level_q == '0);
   assign rd_acc = tx_fifo_rd_en && !empty;
   assign wr_acc = tx_fifo_wr_en && (!full || rd_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_acc && !rd_acc)      level_d = level_q + LVL_ONE;
      else if (rd_acc && !wr_acc) level_d = level_q - LVL_ONE;
   end

   // Storage has no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= tx_fifo_wr_data;
   end

   crc32_byte_step u_crc_step (
      .crc_i  (crc_q),
      .data_i (data_in),
      .crc_o  (crc_next)
   );

   always_comb begin
      if (crc_init)    crc_d = crc_next;
      else if (crc_en) crc_d = crc_q;
      else             crc_d = CRC32_INIT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         rd_data_q <= 8'h00;
         crc_q     <= CRC32_INIT;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         crc_q    <= crc_d;
         if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
      end
   end

`ifdef MAC_TX_FIFO_ERR_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (tx_fifo_wr_en && !wr_acc) overflow_q  <= 1'b1;
         if (tx_fifo_rd_en && empty)   underflow_q <= 1'b1;
      end
   end

   assign tx_fifo_overflow  = overflow_q;
   assign tx_fifo_underflow = underflow_q;
`endif

   assign tx_fifo_rd_data = rd_data_q;
   assign tx_fifo_full    = full;
   assign tx_fifo_empty   = empty;
   assign tx_fifo_level   = level_q;
   assign crc_out         = ~crc_q;

endmodule

// File: tb/tb_mac_tx_fifo_crc.sv
// Bench for mac_tx_fifo_crc: queue model of the FIFO and a message-level CRC-32 model.
module tb_mac_tx_fifo_crc;

   localparam int DEPTH = 2048;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  wr_data;
   logic        wr_en, rd_en;
   logic [7:0]  rd_data;
   logic        full, empty;
   logic [11:0] level;
   logic [7:0]  data_in;
   logic        crc_init, crc_en;
   logic [31:0] crc_out;
   logic        ovf, udf;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic [7:0] crc_msg[$];
   logic [7:0] exp_rd;
   logic       exp_ovf, exp_udf;

   always #5 clk = ~clk;

   mac_tx_fifo_crc dut (
      .clk             (clk),
      .rst             (rst),
      .tx_fifo_wr_data (wr_data),
      .tx_fifo_wr_en   (wr_en),
      .tx_fifo_rd_en   (rd_en),
      .tx_fifo_rd_data (rd_data),
      .tx_fifo_full    (full),
      .tx_fifo_empty   (empty),
      .tx_fifo_level   (level),
      .data_in         (data_in),
      .crc_init        (crc_init),
      .crc_en          (crc_en),
      .crc_out         (crc_out)
`ifdef MAC_TX_FIFO_ERR_EN
      ,
      .tx_fifo_overflow  (ovf),
      .tx_fifo_underflow (udf)
`endif
   );

`ifndef MAC_TX_FIFO_ERR_EN
   assign ovf = 1'b0;
   assign udf = 1'b0;
`endif

   // Textbook CRC-32: MSB-first over 0x04C11DB7 on bit-reversed bytes, result reflected back.
   function automatic logic [31:0] crc_reg_of(input logic [7:0] msg[$]);
      logic [31:0] c;
      logic [31:0] r;
      c = 32'hFFFFFFFF;
      foreach (msg[k]) begin
         for (int b = 0; b < 8; b++) c[31-b] = c[31-b] ^ msg[k][b];
         for (int s = 0; s < 8; s++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
      for (int b = 0; b < 32; b++) r[b] = c[31-b];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
      check({tag, ".level"},   32'(level),   32'(exp_q.size()));
      check({tag, ".empty"},   32'(empty),   32'(exp_q.size() == 0));
      check({tag, ".full"},    32'(full),    32'(exp_q.size() == DEPTH));
      check({tag, ".crc_out"}, crc_out,      ~crc_reg_of(crc_msg));
`ifdef MAC_TX_FIFO_ERR_EN
      check({tag, ".overflow"},  32'(ovf), 32'(exp_ovf));
      check({tag, ".underflow"}, 32'(udf), 32'(exp_udf));
`endif
   endtask

   // One clock: drive inputs, advance the model at the edge, check outputs 1 ns later.
   task automatic cycle(input string tag, input logic r, input logic we, input logic [7:0] wd,
                        input logic re, input logic ci, input logic ce, input logic [7:0] di);
      logic ra, wa;
      rst = r; wr_en = we; wr_data = wd; rd_en = re;
      crc_init = ci; crc_en = ce; data_in = di;
      @(posedge clk);
      if (r) begin
         exp_q.delete(); crc_msg.delete();
         exp_rd = 8'h00; exp_ovf = 1'b0; exp_udf = 1'b0;
      end else begin
         ra = re && (exp_q.size() != 0);
         wa = we && ((exp_q.size() < DEPTH) || ra);
         if (we && !wa) exp_ovf = 1'b1;
         if (re && exp_q.size() == 0) exp_udf = 1'b1;
         if (ra) exp_rd = exp_q.pop_front();
         if (wa) exp_q.push_back(wd);
         if (ci)       crc_msg.push_back(di);
         else if (!ce) crc_msg.delete();
      end
      #1;
      check_all(tag);
   endtask

   logic [7:0] vec [13];

   initial begin
      vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
      exp_rd = 8'h00; exp_ovf = 1'b0; exp_udf = 1'b0;

      // Reset then idle
      cycle("rst", 1, 0, 8'h00, 0, 0, 0, 8'h00);
      cycle("rst", 1, 0, 8'h00, 0, 0, 0, 8'h00);
      cycle("idle", 0, 0, 8'h00, 0, 0, 0, 8'h00);
      check("reset_empty", 32'(empty), 32'd1);
      check("reset_crc", crc_out, 32'h00000000);

      // Three writes, three reads, one read on empty
      cycle("wr", 0, 1, 8'h11, 0, 0, 0, 8'h00);
      cycle("wr", 0, 1, 8'h22, 0, 0, 0, 8'h00);
      cycle("wr", 0, 1, 8'h33, 0, 0, 0, 8'h00);
      cycle("rd", 0, 0, 8'h00, 1, 0, 0, 8'h00);
      check("rd_first", 32'(rd_data), 32'h11);
      cycle("rd", 0, 0, 8'h00, 1, 0, 0, 8'h00);
      check("rd_second", 32'(rd_data), 32'h22);
      cycle("rd", 0, 0, 8'h00, 1, 0, 0, 8'h00);
      check("rd_third", 32'(rd_data), 32'h33);
      check("rd_empty_again", 32'(empty), 32'd1);
      cycle("rd_empty", 0, 0, 8'h00, 1, 0, 0, 8'h00);
      check("rd_empty_hold", 32'(rd_data), 32'h33);
`ifdef MAC_TX_FIFO_ERR_EN
      check("underflow_set", 32'(udf), 32'd1);
`endif

      // Fill to DEPTH, drop one write, then read+write while full
      cycle("rst_fill", 1, 0, 8'h00, 0, 0, 0, 8'h00);
      for (int i = 0; i < DEPTH; i++) cycle("fill", 0, 1, 8'(i), 0, 0, 0, 8'h00);
      check("fill_full", 32'(full), 32'd1);
      check("fill_level", 32'(level), 32'd2048);
      cycle("drop", 0, 1, 8'hAA, 0, 0, 0, 8'h00);
      check("drop_level", 32'(level), 32'd2048);
`ifdef MAC_TX_FIFO_ERR_EN
      check("overflow_set", 32'(ovf), 32'd1);
`endif
      for (int k = 0; k < 4; k++) begin
         cycle("full_rdwr", 0, 1, 8'(8'hC0 + k), 1, 0, 0, 8'h00);
         check("full_rdwr_data", 32'(rd_data), 32'(k));
         check("full_rdwr_level", 32'(level), 32'd2048);
      end

      // CRC of "123456789", hold, reload; then residue over data + FCS
      for (int i = 0; i < 9; i++) cycle("crc_acc", 0, 0, 8'h00, 0, 1, 0, vec[i]);
      cycle("crc_hold", 0, 0, 8'h00, 0, 0, 1, 8'h55);
      check("crc_check", crc_out, 32'hCBF43926);
      cycle("crc_hold", 0, 0, 8'h00, 0, 0, 1, 8'hAA);
      check("crc_held", crc_out, 32'hCBF43926);
      cycle("crc_reload", 0, 0, 8'h00, 0, 0, 0, 8'h00);
      check("crc_reload", crc_out, 32'h00000000);
      for (int i = 0; i < 13; i++) cycle("crc_res", 0, 0, 8'h00, 0, 1, i[0], vec[i]);
      cycle("crc_res_hold", 0, 0, 8'h00, 0, 0, 1, 8'h00);
      check("crc_residue", crc_out, 32'h2144DF1C);

      // Randomized mixed traffic from an empty FIFO
      cycle("rst_rand", 1, 0, 8'h00, 0, 0, 0, 8'h00);
      for (int i = 0; i < 600; i++)
         cycle("rand", 0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
      for (int i = 0; i < 400; i++)
         cycle("rand_drain", 0, 1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

      // Reset mid-stream with buffered bytes and a partial CRC
      for (int i = 0; i < 5; i++) cycle("pre_rst", 0, 1, 8'($urandom), 0, 1, 0, 8'($urandom));
      cycle("rd_pre_rst", 0, 0, 8'h00, 1, 0, 1, 8'h00);
      cycle("mid_rst", 1, 1, 8'h77, 1, 1, 1, 8'h12);
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_crc", crc_out, 32'h00000000);
      check("mid_rst_rd_data", 32'(rd_data), 32'h00);
`ifdef MAC_TX_FIFO_ERR_EN
      check("mid_rst_ovf", 32'(ovf), 32'd0);
      check("mid_rst_udf", 32'(udf), 32'd0);
`endif
      cycle("post_rst", 0, 0, 8'h00, 0, 0, 0, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
